// File: rtl/axi_log_drain_if.sv
// axi_log_drain_if: BRAM read port and AXI-Stream bundle between the log drain and its neighbours
interface axi_log_drain_if;
   logic        BramEn_SO;
   logic [31:0] BramAddr_SO;
   logic [31:0] BramRd_DI;
   logic [31:0] TData_DO;
   logic        TValid_SO;
   logic        TReady_SI;
   logic        TLast_SO;
   modport master (
      output BramEn_SO, BramAddr_SO, TData_DO, TValid_SO, TLast_SO,
      input  BramRd_DI, TReady_SI
   );
   modport slave (
      input  BramEn_SO, BramAddr_SO, TData_DO, TValid_SO, TLast_SO,
      output BramRd_DI, TReady_SI
   );
endinterface

// File: rtl/axi_log_drain.sv
// axi_log_drain: reads logger entries word by word over BRAM and streams them out on AXI-Stream
module axi_log_drain #(
   parameter int WORDS_PER_ENTRY = 3,
   parameter int NUM_SER_BRAMS   = 12,
   parameter int CNT_BITW        = 14,
   parameter bit AUTO_DRAIN      = 1'b1
) (
   input  logic                Clk_CI,
   input  logic                Rst_RI,
   input  logic                Start_SI,
   input  logic [CNT_BITW-1:0] NumEntries_DI,
   input  logic                LogFull_SI,
   output logic                Busy_SO,
   output logic                Done_SO,
   output logic                LogClear_SO,
   axi_log_drain_if.master     bus
);
   localparam int CW = CNT_BITW + 2;
   localparam logic [CW-1:0] MAX_N = CW'(1024 * NUM_SER_BRAMS);
   localparam logic [CW-1:0] WPE = CW'(WORDS_PER_ENTRY);
   typedef enum logic [1:0] {IDLE, DRAIN, FINISH} state_t;
   state_t        state_q, state_d;
   logic [CW-1:0] w_q, rd_q, tx_q, n_clamp;
   logic          no_clr_q, inflight_q;
   logic [31:0]   fifo_q [2];
   logic          wptr_q, rptr_q;
   logic [1:0]    cnt_q;
   logic          start, issue, pop, push, head_fifo, last_hs;
   assign n_clamp   = (CW'(NumEntries_DI) > MAX_N) ? MAX_N : CW'(NumEntries_DI);
   assign start     = (state_q == IDLE) && (Start_SI || (AUTO_DRAIN && LogFull_SI));
   assign head_fifo = cnt_q != 2'd0;
   // reads only while the FIFO can still absorb every outstanding word
   assign issue     = (state_q == DRAIN) && (rd_q < w_q) && ((cnt_q + {1'b0, inflight_q}) < 2'd2);
   assign pop       = bus.TValid_SO && bus.TReady_SI;
   // a returning word bypasses the empty FIFO when it is accepted straight away
   assign push      = inflight_q && (head_fifo || !pop);
   assign last_hs   = pop && (tx_q == w_q - CW'(1));
   // state register
   always_ff @(posedge Clk_CI) begin
      if (Rst_RI) state_q <= IDLE;
      else state_q <= state_d;
   end
   // next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = (n_clamp == '0) ? FINISH : DRAIN;
         DRAIN:   if (last_hs) state_d = FINISH;
         default: state_d = IDLE;
      endcase
   end
   // output decode: status pulses, BRAM read port and stream head
   always_comb begin
      Busy_SO         = state_q != IDLE;
      Done_SO         = state_q == FINISH;
      LogClear_SO     = (state_q == FINISH) && !no_clr_q;
      bus.BramEn_SO   = issue;
      bus.BramAddr_SO = issue ? {{(30-CW){1'b0}}, rd_q, 2'b00} : 32'd0;
      bus.TValid_SO   = (state_q == DRAIN) && (head_fifo || inflight_q);
      bus.TData_DO    = head_fifo ? fifo_q[rptr_q] : (inflight_q ? bus.BramRd_DI : 32'd0);
      bus.TLast_SO    = bus.TValid_SO && (tx_q == w_q - CW'(1));
   end
   // word counters, read-in-flight flag and the two-entry FIFO
   always_ff @(posedge Clk_CI) begin
      if (Rst_RI) begin
         w_q        <= '0;
         rd_q       <= '0;
         tx_q       <= '0;
         no_clr_q   <= 1'b0;
         inflight_q <= 1'b0;
         fifo_q[0]  <= '0;
         fifo_q[1]  <= '0;
         wptr_q     <= 1'b0;
         rptr_q     <= 1'b0;
         cnt_q      <= '0;
      end else begin
         if (start) begin
            w_q      <= n_clamp * WPE;
            no_clr_q <= n_clamp == '0;
            rd_q     <= '0;
            tx_q     <= '0;
         end else begin
            rd_q <= rd_q + CW'(issue);
            tx_q <= tx_q + CW'(pop);
         end
         inflight_q <= issue;
         if (push) begin
            fifo_q[wptr_q] <= bus.BramRd_DI;
            wptr_q         <= !wptr_q;
         end
         if (pop && head_fifo) rptr_q <= !rptr_q;
         cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop && head_fifo};
      end
   end
endmodule

// File: tb/tb_axi_log_drain.sv
// tb_axi_log_drain: table-driven and randomized drains checked against a word-sequence model
module tb_axi_log_drain;
   localparam int MAXN = 12288;
   logic        clk = 1'b0, rst = 1'b1, start = 1'b0, full = 1'b0;
   logic [13:0] num = '0;
   logic        busy, done, clr;
   int          total = 0, bad = 0;
   axi_log_drain_if bus();
   axi_log_drain dut (
      .Clk_CI(clk), .Rst_RI(rst), .Start_SI(start), .NumEntries_DI(num),
      .LogFull_SI(full), .Busy_SO(busy), .Done_SO(done), .LogClear_SO(clr), .bus(bus)
   );
   always #5 clk = ~clk;
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
   endfunction
   // BRAM with one cycle of read latency, holding its output when not enabled
   always @(posedge clk) bus.BramRd_DI <= rst ? 32'd0 : (bus.BramEn_SO ? mem_word(bus.BramAddr_SO) : bus.BramRd_DI);
   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask
   function automatic logic any_out();
      return |{busy, done, clr, bus.BramEn_SO, bus.BramAddr_SO, bus.TData_DO, bus.TValid_SO, bus.TLast_SO};
   endfunction
   task automatic run(input int n, input int mode, input bit via_start, input bit via_full, input bit noise,
                      input int abort_at, input int exp_w, input int exp_clr, input int exp_last);
      int issued = 0, acc = 0, last_hs = -1, first_v = -1, t = 0, done_n = 0, clr_n = 0, done_t = -1;
      int data_e = 0, last_e = 0, stab_e = 0, addr_e = 0, occ_e = 0, busy_e = 0, post_e = 0, quiet = 0;
      int budget;
      logic [31:0] last_addr = '0, pd = '0;
      logic pl = 1'b0, pstall = 1'b0, fin = 1'b0, aborted = 1'b0;
      budget = exp_w * 6 + 40;
      @(posedge clk); #1;
      num = 14'(n);
      start = via_start;
      full = via_full;
      while (!fin) begin
         @(posedge clk); #1;
         t++;
         start = noise && (acc < exp_w) && ($urandom_range(0, 1) == 1);
         full = noise && (acc < exp_w) && ($urandom_range(0, 1) == 1);
         bus.TReady_SI = (mode == 0) ? 1'b1 : (mode == 1) ? ((t % 2) == 1) : ($urandom_range(0, 1) == 1);
         if (abort_at > 0 && acc == abort_at) begin
            rst = 1'b1;
            start = 1'b0;
            full = 1'b0;
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            chk("abort_outputs_zero", any_out(), 0);
            for (int i = 0; i < 4; i++) begin
               @(negedge clk);
               if (busy || done || clr || bus.TValid_SO) quiet++;
            end
            chk("abort_quiet", quiet, 0);
            aborted = 1'b1;
            fin = 1'b1;
         end else begin
            @(negedge clk);
            if (bus.BramEn_SO) begin
               if (bus.BramAddr_SO != 32'(issued * 4)) addr_e++;
               if (issued + 1 - acc > 2) occ_e++;
               last_addr = bus.BramAddr_SO;
               issued++;
            end
            if (pstall && (!bus.TValid_SO || bus.TData_DO != pd || bus.TLast_SO != pl)) stab_e++;
            if (bus.TValid_SO) begin
               if (first_v < 0) first_v = t;
               if (bus.TData_DO != mem_word(32'(acc * 4))) data_e++;
               if (bus.TLast_SO != (acc == exp_w - 1)) last_e++;
               if (bus.TReady_SI) begin
                  acc++;
                  last_hs = t;
               end
            end
            pstall = bus.TValid_SO && !bus.TReady_SI;
            pd = bus.TData_DO;
            pl = bus.TLast_SO;
            if (busy != (done_t < 0)) busy_e++;
            if (done_t >= 0 && (bus.TValid_SO || bus.BramEn_SO)) post_e++;
            if (done) begin
               done_n++;
               if (done_t < 0) done_t = t;
            end
            if (clr) clr_n++;
            if (done_t >= 0 && t >= done_t + 2) fin = 1'b1;
            if (t > budget) begin
               chk("timeout", t, budget);
               fin = 1'b1;
            end
         end
      end
      if (!aborted) begin
         chk("words", acc, exp_w);
         chk("reads", issued, exp_w);
         chk("data_errs", data_e, 0);
         chk("tlast_errs", last_e, 0);
         chk("stable_errs", stab_e, 0);
         chk("addr_errs", addr_e, 0);
         chk("occupancy_errs", occ_e, 0);
         chk("busy_errs", busy_e, 0);
         chk("post_done_activity", post_e, 0);
         chk("done_pulses", done_n, 1);
         chk("clear_pulses", clr_n, exp_clr);
         chk("done_cycle", done_t, exp_w > 0 ? last_hs + 1 : 1);
         chk("first_valid_cycle", first_v, exp_w > 0 ? 2 : -1);
         chk("last_addr", last_addr, exp_last);
      end
   endtask
   typedef struct {
      int n; int mode; bit via_start; bit via_full; bit noise; int abort_at;
      int exp_w; int exp_clr; int exp_last;
   } vec_t;
   vec_t tbl [7];
   initial begin
      tbl[0] = '{2,     0, 1'b1, 1'b0, 1'b0, 0, 6,     1, 'h14};
      tbl[1] = '{1,     1, 1'b1, 1'b0, 1'b0, 0, 3,     1, 'h08};
      tbl[2] = '{0,     0, 1'b1, 1'b0, 1'b0, 0, 0,     0, 0};
      tbl[3] = '{3,     0, 1'b1, 1'b0, 1'b0, 4, 9,     1, 0};
      tbl[4] = '{1,     0, 1'b1, 1'b0, 1'b0, 0, 3,     1, 'h08};
      tbl[5] = '{5,     1, 1'b0, 1'b1, 1'b0, 0, 15,    1, 'h38};
      tbl[6] = '{16383, 0, 1'b1, 1'b1, 1'b1, 0, 36864, 1, 'h23FFC};
      bus.TReady_SI = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_outputs_zero", any_out(), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 7; i++)
         run(tbl[i].n, tbl[i].mode, tbl[i].via_start, tbl[i].via_full, tbl[i].noise,
             tbl[i].abort_at, tbl[i].exp_w, tbl[i].exp_clr, tbl[i].exp_last);
      for (int i = 0; i < 12; i++) begin
         int n, w;
         n = $urandom_range(0, 20);
         w = (n < MAXN ? n : MAXN) * 3;
         run(n, 2, 1'b1, $urandom_range(0, 1) == 1, 1'b1, 0, w, n != 0, w > 0 ? (w - 1) * 4 : 0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
